mux_nto1_arb: RTL and testbench

- Parametrised successor to the team's 2:1 single-bit mux.
- Selects one of N input channels, each W bits wide, with valid/ready flow control per channel.
- Output stage is a one-entry registered buffer.
- Two selection modes: direct select (steered by a select port) and round-robin arbitration.
- Sits between datapath producers and a single shared consumer, e.g. a display or register-file write port.

---
 rtl/mux_pkg.sv | 26 ++
 rtl/mux_nto1_arb_rr_arbiter.sv | 31 +++
 rtl/mux_nto1_arb.sv | 96 +++++++++
 tb/tb_mux_nto1_arb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 valid/ready channel mux.
// Holds mode encodings, default sizing and the channel slice helper.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    localparam int MAX_N   = 16;
    localparam int MAX_W   = 64;
    localparam int MAX_BUS = MAX_N * MAX_W;

    // Bus is zero-extended to the largest legal size so one helper serves every N/W.
    function automatic logic [MAX_W-1:0] chan_slice(
        input logic [MAX_BUS-1:0] bus,
        input int                 idx,
        input int                 w
    );
        logic [MAX_BUS-1:0] sh;
        sh = bus >> (idx * w);
        return sh[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/mux_nto1_arb_rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Searches ptr+1, ptr+2, ... modulo N and grants the first requester.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx
);

    logic [SW-1:0] idx;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = SW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_arb.sv
// N:1 valid/ready channel mux with direct-select or round-robin grant
// feeding a one-entry registered output buffer.
module mux_nto1_arb
    import mux_pkg::*;
#(
    parameter  int N  = DEF_N,
    parameter  int W  = DEF_W,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]  in_valid,
    output logic [N-1:0]  in_ready,
    input  logic          mode,
    input  logic [SW-1:0] sel,
    output logic [W-1:0]  out_data,
    output logic [SW-1:0] out_chan,
    output logic          out_valid,
    input  logic          out_ready
);

    logic [W-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_chan_q,  out_chan_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] rr_ptr_q,    rr_ptr_d;

    logic [N-1:0]  rr_gnt;
    logic [SW-1:0] rr_idx;
    logic [N-1:0]  dir_gnt;
    logic [N-1:0]  grant;
    logic [SW-1:0] g_idx;
    logic          can_load;
    logic          xfer;
    logic [MAX_BUS-1:0] bus_ext;

    rr_arbiter #(.N(N)) u_rr (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    // Out-of-range sel never matches any channel, so it grants nothing.
    always_comb begin
        dir_gnt = '0;
        for (int i = 0; i < N; i++) begin
            dir_gnt[i] = (sel == SW'(i)) && in_valid[i];
        end
    end

    always_comb begin
        can_load = !out_valid_q || out_ready;
        grant    = (mode == MODE_RR) ? rr_gnt : dir_gnt;
        g_idx    = (mode == MODE_RR) ? rr_idx : sel;
        in_ready = grant & {N{can_load}};
        xfer     = |in_ready;
        bus_ext  = MAX_BUS'(in_data);
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = W'(chan_slice(bus_ext, int'(g_idx), W));
            out_chan_d  = g_idx;
            out_valid_d = 1'b1;
            if (mode == MODE_RR) begin
                rr_ptr_d = g_idx;
            end
        end else if (can_load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_arb.sv
// Scoreboard bench for mux_nto1_arb: driver predicts beats, monitor checks them.
// A second instance with N=3 covers the out-of-range select case.
module tb_mux_nto1_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic           mode = 1'b0;
    logic [SW-1:0]  sel = '0;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_chan;
    logic           out_valid;
    logic           out_ready = 1'b0;

    logic [3*W-1:0] in_data3 = '0;
    logic [2:0]     in_valid3 = '0;
    logic [2:0]     in_ready3;
    logic [1:0]     sel3 = 2'd3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_chan3;
    logic           out_valid3;

    always #5 clk = ~clk;

    mux_nto1_arb #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel),
        .out_data(out_data), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_nto1_arb #(.N(3), .W(W)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(1'b0), .sel(sel3),
        .out_data(out_data3), .out_chan(out_chan3),
        .out_valid(out_valid3), .out_ready(1'b1)
    );

    int tests = 0;
    int fails = 0;

    int          qc[$];
    logic [W-1:0] qd[$];

    bit       mvalid = 1'b0;
    int       mptr   = N - 1;
    logic [N-1:0] last_acc = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant: build the priority order, then take the first valid channel.
    function automatic int model_grant(input logic [N-1:0] v, input logic m, input logic [SW-1:0] s);
        int order[$];
        if (!m) begin
            if (int'(s) < N && v[s]) return int'(s);
            return -1;
        end
        for (int k = 1; k <= N; k++) order.push_back((mptr + k) % N);
        foreach (order[j]) if (v[order[j]]) return order[j];
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic m, input logic [SW-1:0] s, input logic r);
        int   g;
        bit   can;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        chk("out_valid", out_valid, mvalid);
        in_valid = v; in_data = d; mode = m; sel = s; out_ready = r;
        #1;
        g = model_grant(v, m, s);
        can = !mvalid || r;
        exp_rdy = '0;
        if (g >= 0 && can) exp_rdy[g] = 1'b1;
        chk("in_ready", in_ready, exp_rdy);
        last_acc = exp_rdy;
        if (exp_rdy != 0) begin
            qc.push_back(g);
            qd.push_back(d[g*W +: W]);
            mvalid = 1'b1;
            if (m) mptr = g;
        end else if (can) begin
            mvalid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = '0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst out_chan", out_chan, 0);
        qc.delete(); qd.delete();
        mvalid = 1'b0; mptr = N - 1; last_acc = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: a beat is new when out_valid is seen after an edge where the
    // buffer was empty or being drained; otherwise it must be unchanged.
    initial begin
        logic pre_v, pre_r;
        int   hc;
        logic [W-1:0] hd;
        hc = 0; hd = '0;
        forever begin
            @(negedge clk); #2;
            pre_v = out_valid; pre_r = out_ready;
            @(posedge clk); #1;
            if (rst_n && out_valid) begin
                if (!pre_v || pre_r) begin
                    if (qc.size() == 0) begin
                        chk("unexpected beat", 1, 0);
                    end else begin
                        hc = qc.pop_front(); hd = qd.pop_front();
                        chk("out_chan", out_chan, hc);
                        chk("out_data", out_data, hd);
                    end
                end else begin
                    chk("held out_chan", out_chan, hc);
                    chk("held out_data", out_data, hd);
                end
            end
        end
    end

    initial begin
        logic [N-1:0]   cv;
        logic [N*W-1:0] cd;
        logic           m;
        logic [SW-1:0]  s;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fill the buffer, then reset while it holds a beat.
        step(4'hF, 32'h44332211, 1'b1, 2'd0, 1'b0);
        step(4'hF, 32'h44332211, 1'b1, 2'd0, 1'b0);
        do_reset();
        step(4'hF, 32'h44332211, 1'b1, 2'd0, 1'b1);
        chk("first rr grant ch0", in_ready, 4'b0001);

        step(4'hF, 32'h44A52211, 1'b0, 2'd2, 1'b1);
        chk("direct sel2", in_ready, 4'b0100);

        for (int i = 0; i < 6; i++)
            step(4'hF, 32'h44332211 + {4{8'(i)}}, 1'b1, 2'd0, 1'b1);

        step(4'b0010, 32'h00005500, 1'b1, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++)
            step(4'b1010, 32'h70006000 + {4{8'(i)}}, 1'b1, 2'd0, 1'b1);

        step(4'b0100, 32'h00C30000, 1'b0, 2'd2, 1'b1);
        for (int i = 0; i < 5; i++)
            step(4'b0001, 32'h0000005A, 1'b0, 2'd0, 1'b0);
        step(4'b0001, 32'h0000005A, 1'b0, 2'd0, 1'b1);
        step(4'b0000, 32'h0, 1'b0, 2'd0, 1'b0);

        // N=3 instance with sel=3 must never grant.
        in_valid3 = 3'b111; in_data3 = 24'hCCBBAA;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("oor in_ready", in_ready3, 0);
            chk("oor out_valid", out_valid3, 0);
        end
        in_valid3 = '0;

        cv = '0; cd = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            m = ((cyc / 300) % 2) != 0;
            s = ($urandom % 6 == 0) ? SW'($urandom % N) : sel;
            for (int i = 0; i < N; i++) begin
                if (cv[i] && !last_acc[i]) begin
                    if ($urandom % 5 == 0) cv[i] = 1'b0;
                end else begin
                    cv[i] = ($urandom % 3) != 0;
                    cd[i*W +: W] = W'($urandom);
                end
            end
            step(cv, cd, m, s, ($urandom % 4) != 0);
        end

        for (int i = 0; i < 4; i++) step('0, '0, 1'b0, 2'd0, 1'b1);
        chk("scoreboard drained", qc.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
